ssd_display_ctrl: RTL



---
 rtl/ssd_pkg.sv | 24 ++
 rtl/bcd2_seq.sv | 54 +++++
 rtl/ssd_display_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the two-digit seven-segment display path.
//   SSD_VAL_W     : width of a displayable binary value (0..127)
//   BCD_W         : width of one BCD digit
//   BCD_DASH      : digit code that ssd_display renders as a dash
//   SSD_MAX_SHOWN : largest value that fits on two decimal digits
//   BCD_RADIX     : subtrahend of the subtract-by-ten converter
//   ssd_state_e   : scheduler FSM states
package ssd_pkg;

    localparam int SSD_VAL_W = 7;
    localparam int BCD_W     = 4;

    localparam logic [BCD_W-1:0]     BCD_DASH      = 4'hF;
    localparam logic [SSD_VAL_W-1:0] SSD_MAX_SHOWN = 7'd99;
    localparam logic [SSD_VAL_W-1:0] BCD_RADIX     = 7'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_DONE
    } ssd_state_e;

endpackage

// File: rtl/bcd2_seq.sv
// Sequential binary-to-two-digit-BCD converter (subtract by ten per cycle).
//   clk, rst : clock, synchronous active-high reset
//   start    : load value and begin a conversion
//   value    : binary input, 0..99 expected
//   busy     : a subtract step happens this cycle
//   done     : this cycle's subtract is the final one; ones/tens are final
//              on the next cycle
//   ones     : ones BCD digit
//   tens     : tens BCD digit
// Values below ten never set busy, so their result is ready one cycle
// after start. Otherwise the final subtract is flagged early so the caller
// can leave its wait state without spending an extra cycle on the check.
module bcd2_seq
    import ssd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SSD_VAL_W-1:0] value,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W-1:0]     ones,
    output logic [BCD_W-1:0]     tens
);

    localparam logic [SSD_VAL_W-1:0] LAST_STEP_LIMIT = BCD_RADIX + BCD_RADIX;

    logic [SSD_VAL_W-1:0] rem;
    logic [BCD_W-1:0]     tens_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            tens_q <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            rem    <= value;
            tens_q <= '0;
            busy   <= (value >= BCD_RADIX);
        end else if (busy) begin
            // busy implies rem >= 10, so this never underflows
            rem    <= rem - BCD_RADIX;
            tens_q <= tens_q + 4'd1;
            if (rem < LAST_STEP_LIMIT) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (rem < LAST_STEP_LIMIT);
    assign ones = rem[BCD_W-1:0];
    assign tens = tens_q;

endmodule

// File: rtl/ssd_display_ctrl.sv
// Round-robin display scheduler for the two-digit PmodSSD.
//   clk, rst    : clock, synchronous active-high reset
//   src_valid   : per-source request for display time
//   src_value   : packed 7-bit binary values, source i at [7i+6:7i]
//   src_blink   : per-source blink request
//   digit_one   : ones BCD digit to ssd_display
//   digit_two   : tens BCD digit to ssd_display
//   one_en      : ones digit enable (low shows a dash)
//   two_en      : tens digit enable
//   cur_src     : index of the source on the display
//   disp_update : one-cycle pulse when the outputs above commit
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | first cycle after reset
// LOAD    | pick source (advance on slot expiry / invalid), latch value
// CONV    | converter subtracting tens
// DONE    | commit digits/enables, pulse disp_update
module ssd_display_ctrl
    import ssd_pkg::*;
#(
    parameter  int N_SRC        = 3,
    parameter  int DWELL_CYCLES = 200_000_000,
    parameter  int BLINK_CYCLES = 25_000_000,
    localparam int SEL_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [SSD_VAL_W*N_SRC-1:0] src_value,
    input  logic [N_SRC-1:0]           src_blink,
    output logic [BCD_W-1:0]           digit_one,
    output logic [BCD_W-1:0]           digit_two,
    output logic                       one_en,
    output logic                       two_en,
    output logic [SEL_W-1:0]           cur_src,
    output logic                       disp_update
);

    localparam int TMR_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);

    ssd_state_e state, state_nxt;

    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     sel_adv;
    logic [SEL_W-1:0]     cand;
    logic                 adv_found;
    logic [SEL_W-1:0]     load_sel;
    logic [SSD_VAL_W-1:0] load_val;
    logic                 load_blink;
    logic                 load_ovf;
    logic                 any_valid;
    logic                 need_adv;

    logic [TMR_W-1:0]     slot_tmr;
    logic                 switch_pending;
    logic [BLK_W-1:0]     blink_cnt;
    logic                 blink_phase;

    logic                 blink_l;
    logic                 ovf_l;
    logic                 blank_l;
    logic                 en_gate;

    logic                 conv_start;
    logic                 conv_busy;
    logic                 conv_done;
    logic [BCD_W-1:0]     conv_ones;
    logic [BCD_W-1:0]     conv_tens;

    // Next valid index strictly after sel, wrapping; the final candidate is
    // sel itself so a lone valid source re-selects itself on expiry.
    always_comb begin
        sel_adv   = sel;
        adv_found = 1'b0;
        cand      = sel;
        for (int i = 0; i < N_SRC; i++) begin
            cand = (cand == SEL_LAST) ? '0 : cand + 1'b1;
            if (!adv_found && src_valid[cand]) begin
                adv_found = 1'b1;
                sel_adv   = cand;
            end
        end
    end

    assign any_valid  = |src_valid;
    assign need_adv   = switch_pending || !src_valid[sel];
    assign load_sel   = need_adv ? sel_adv : sel;
    assign load_val   = src_value[load_sel*SSD_VAL_W +: SSD_VAL_W];
    assign load_blink = src_blink[load_sel];
    assign load_ovf   = (load_val > SSD_MAX_SHOWN);
    assign en_gate    = !blink_l || blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (!any_valid || load_ovf) begin
                    state_nxt = ST_DONE;
                end else begin
                    conv_start = 1'b1;
                    // single-digit values are already final after the load
                    state_nxt  = (load_val >= BCD_RADIX) ? ST_CONV : ST_DONE;
                end
            end
            ST_CONV: begin
                if (conv_done || !conv_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    bcd2_seq u_bcd2_seq (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (load_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .ones  (conv_ones),
        .tens  (conv_tens)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // A switch in LOAD restarts the slot, taking priority over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_tmr       <= '0;
            switch_pending <= 1'b0;
        end else if (state == ST_LOAD && need_adv) begin
            slot_tmr       <= '0;
            switch_pending <= 1'b0;
        end else if (any_valid) begin
            if (slot_tmr == TMR_LAST) begin
                slot_tmr       <= '0;
                switch_pending <= 1'b1;
            end else begin
                slot_tmr <= slot_tmr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            blink_l <= 1'b0;
            ovf_l   <= 1'b0;
            blank_l <= 1'b0;
        end else if (state == ST_LOAD) begin
            sel     <= load_sel;
            blink_l <= load_blink;
            ovf_l   <= load_ovf;
            blank_l <= !any_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_one   <= '0;
            digit_two   <= '0;
            one_en      <= 1'b0;
            two_en      <= 1'b0;
            cur_src     <= '0;
            disp_update <= 1'b0;
        end else begin
            disp_update <= (state == ST_DONE);
            if (state == ST_DONE) begin
                if (blank_l) begin
                    // digits and source index hold; only the enables drop
                    one_en <= 1'b0;
                    two_en <= 1'b0;
                end else begin
                    if (ovf_l) begin
                        digit_one <= BCD_DASH;
                        digit_two <= BCD_DASH;
                    end else begin
                        digit_one <= conv_ones;
                        digit_two <= conv_tens;
                    end
                    one_en  <= en_gate;
                    two_en  <= en_gate;
                    cur_src <= sel;
                end
            end
        end
    end

endmodule
